// File: rtl/y86_pkg.sv
// Shared Y86 fetch definitions: icode constants, the "no register" marker and the fetch FSM states.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVL = 4'h2;
  localparam logic [3:0] IIRMOVL = 4'h3;
  localparam logic [3:0] IOPL    = 4'h6;
  localparam logic [3:0] RNONE   = 4'hF;

  typedef enum logic [2:0] {
    S_OPC,
    S_REGS,
    S_IMM,
    S_PRESENT,
    S_STOP,
    S_ERR
  } fetch_state_t;

endpackage

// File: rtl/y86_fetch_len.sv
// Combinational icode classifier: which trailing bytes an instruction carries and whether it is legal.
module y86_fetch_len
  import y86_pkg::*;
(
  input  logic [3:0] i_icode,
  output logic       o_needs_regs,
  output logic       o_needs_imm,
  output logic       o_legal
);

  always_comb begin
    o_needs_regs = 1'b0;
    o_needs_imm  = 1'b0;
    o_legal      = 1'b1;
    case (i_icode)
      IHALT, INOP:   ;
      IRRMOVL, IOPL: o_needs_regs = 1'b1;
      IIRMOVL: begin
        o_needs_regs = 1'b1;
        o_needs_imm  = 1'b1;
      end
      default:       o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/y86_fetch.sv
// Byte-serial Y86 instruction fetch: reads opcode, register and immediate bytes, then presents the instruction.
// Y86_FETCH_ILLEGAL_TRAP_EN: when defined, an illegal icode traps into ERR; otherwise it is fetched as a NOP.
module y86_fetch
  import y86_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            resetn,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [7:0]      imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [3:0]      icode,
  output logic [3:0]      ifun,
  output logic [3:0]      rA,
  output logic [3:0]      rB,
  output logic [31:0]     valC,
  output logic [PC_W-1:0] valP,
  output logic            halted,
  output logic            ierr
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  fetch_state_t    r_state, w_next;
  logic [PC_W-1:0] r_pc;
  logic [1:0]      r_cnt;
  logic [3:0]      r_icode, r_ifun, r_ra, r_rb;
  logic [31:0]     r_valc;
  logic            r_imm;
  logic            w_fire;
  logic            w_needs_regs, w_needs_imm, w_legal;
  logic [3:0]      w_icode_cap;

  y86_fetch_len u_len (
    .i_icode      (imem_rdata[7:4]),
    .o_needs_regs (w_needs_regs),
    .o_needs_imm  (w_needs_imm),
    .o_legal      (w_legal)
  );

  always_comb begin
    w_next      = r_state;
    imem_req    = 1'b0;
    inst_valid  = 1'b0;
    halted      = 1'b0;
    ierr        = 1'b0;
    w_icode_cap = imem_rdata[7:4];
`ifdef Y86_FETCH_ILLEGAL_TRAP_EN
`else
    if (!w_legal) w_icode_cap = INOP;
`endif
    case (r_state)
      S_OPC: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (!w_legal) begin
`ifdef Y86_FETCH_ILLEGAL_TRAP_EN
            w_next = S_ERR;
`else
            w_next = S_PRESENT;
`endif
          end else if (w_needs_regs) begin
            w_next = S_REGS;
          end else begin
            w_next = S_PRESENT;
          end
        end
      end
      S_REGS: begin
        imem_req = 1'b1;
        if (imem_ack) w_next = r_imm ? S_IMM : S_PRESENT;
      end
      S_IMM: begin
        imem_req = 1'b1;
        if (imem_ack && (r_cnt == 2'd3)) w_next = S_PRESENT;
      end
      S_PRESENT: begin
        inst_valid = 1'b1;
        if (inst_ready) w_next = (r_icode == IHALT) ? S_STOP : S_OPC;
      end
      S_STOP: halted = 1'b1;
      S_ERR: begin
`ifdef Y86_FETCH_ILLEGAL_TRAP_EN
        ierr = 1'b1;
`endif
      end
      default: w_next = S_OPC;
    endcase
    // The request is withheld while reset is asserted, even though the state already reads OPC.
    if (!resetn) imem_req = 1'b0;
  end

  assign w_fire = imem_req & imem_ack;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_OPC;
      r_pc    <= RESET_PC;
      r_cnt   <= 2'd0;
      r_icode <= IHALT;
      r_ifun  <= 4'h0;
      r_ra    <= RNONE;
      r_rb    <= RNONE;
      r_valc  <= 32'h0;
      r_imm   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_fire) begin
        r_pc <= r_pc + PC_ONE;
        case (r_state)
          S_OPC: begin
            r_icode <= w_icode_cap;
            r_ifun  <= imem_rdata[3:0];
            r_ra    <= RNONE;
            r_rb    <= RNONE;
            r_valc  <= 32'h0;
            r_cnt   <= 2'd0;
            r_imm   <= w_needs_imm;
          end
          S_REGS: begin
            r_ra <= imem_rdata[7:4];
            r_rb <= imem_rdata[3:0];
          end
          S_IMM: begin
            // Little-endian: the first immediate byte lands in valC[7:0].
            case (r_cnt)
              2'd0:    r_valc[7:0]   <= imem_rdata;
              2'd1:    r_valc[15:8]  <= imem_rdata;
              2'd2:    r_valc[23:16] <= imem_rdata;
              default: r_valc[31:24] <= imem_rdata;
            endcase
            r_cnt <= r_cnt + 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign imem_addr = r_pc;
  assign icode     = r_icode;
  assign ifun      = r_ifun;
  assign rA        = r_ra;
  assign rB        = r_rb;
  assign valC      = r_valc;
  assign valP      = r_pc;

endmodule
